// File: rtl/xevious_input_cond.sv
// xevious_input_cond: conditions the HPS joystick word for the xevious core.
// Coin/start presses become fixed-length pulses counted in vblank frames,
// followed by a lockout gap and a mandatory release. Opposing directions are
// resolved per axis (neutral, or last-pressed-wins). All outputs are registered.
// Optional feature macro: XEVIOUS_INPUT_AUTOFIRE_EN (adds frame-counted autofire
// on the fire button; when undefined the autofire port is ignored).
module xevious_input_cond #(
   parameter int unsigned PULSE_FRAMES    = 3,
   parameter int unsigned GAP_FRAMES      = 4,
   parameter int unsigned AUTOFIRE_FRAMES = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        vblank,
   input  logic        pause,
   input  logic [15:0] joy_in,
   input  logic        socd_mode,
   input  logic        autofire,
   output logic        up,
   output logic        down,
   output logic        left,
   output logic        right,
   output logic        fire,
   output logic        bomb,
   output logic        start1,
   output logic        start2,
   output logic        coin,
   output logic        frame_tick
);

   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_FRAMES);
   localparam logic [7:0] GAP_LOAD   = 8'(GAP_FRAMES);

   // Pulsed channel states; index 0 = start1, 1 = start2, 2 = coin
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_GAP,
      ST_RELEASE
   } pulse_state_t;

   logic [8:0]   in_r;
   logic [3:0]   in_prev;
   logic         vblank_d;
   logic         tick;
   logic [2:0]   ch_in;

   pulse_state_t ch_state_q [3];
   pulse_state_t ch_state_d [3];
   logic [7:0]   ch_cnt_q   [3];
   logic [7:0]   ch_cnt_d   [3];
   logic [2:0]   ch_out_q;
   logic [2:0]   ch_out_d;

   logic         newer_ud_q, tie_ud_q, newer_lr_q, tie_lr_q;
   logic [3:0]   ud_res, lr_res;
   logic         fire_d;

   // Raw joystick sampling; runs through reset so a held button is seen as held
   always_ff @(posedge clk_sys) begin
      in_r    <= joy_in[8:0];
      in_prev <= in_r[3:0];
   end

   // vblank edge history; preset high so no tick fires if vblank is high at reset release
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         vblank_d <= 1'b1;
      end else begin
         vblank_d <= vblank;
      end
   end

   assign tick  = vblank & ~vblank_d & ~pause;
   assign ch_in = {in_r[8], in_r[7], in_r[6]};

   // Resolve one direction axis: tracks which side was pressed most recently and
   // whether both sides came down together (held neutral until one lets go)
   function automatic logic [3:0] socd_axis(
      input logic a,
      input logic b,
      input logic a_rise,
      input logic b_rise,
      input logic newer_q,
      input logic tie_q,
      input logic mode
   );
      logic newer_d;
      logic tie_d;
      logic a_o;
      logic b_o;
      newer_d = newer_q;
      if (a_rise && !b_rise) begin
         newer_d = 1'b0;
      end else if (b_rise && !a_rise) begin
         newer_d = 1'b1;
      end
      if (a_rise && b_rise) begin
         tie_d = 1'b1;
      end else begin
         tie_d = tie_q & a & b;
      end
      if (a && b) begin
         if (mode && !tie_d) begin
            a_o = ~newer_d;
            b_o = newer_d;
         end else begin
            a_o = 1'b0;
            b_o = 1'b0;
         end
      end else begin
         a_o = a;
         b_o = b;
      end
      return {newer_d, tie_d, a_o, b_o};
   endfunction

   // Axis resolution from the current sample and its predecessor (rise detect)
   always_comb begin
      ud_res = socd_axis(in_r[3], in_r[2], in_r[3] & ~in_prev[3], in_r[2] & ~in_prev[2],
                         newer_ud_q, tie_ud_q, socd_mode);
      lr_res = socd_axis(in_r[1], in_r[0], in_r[1] & ~in_prev[1], in_r[0] & ~in_prev[0],
                         newer_lr_q, tie_lr_q, socd_mode);
   end

   // Per-axis "newer side" and "simultaneous press" memory
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         newer_ud_q <= 1'b0;
         tie_ud_q   <= 1'b0;
         newer_lr_q <= 1'b0;
         tie_lr_q   <= 1'b0;
      end else begin
         newer_ud_q <= ud_res[3];
         tie_ud_q   <= ud_res[2];
         newer_lr_q <= lr_res[3];
         tie_lr_q   <= lr_res[2];
      end
   end

   // Pulse shaping next-state: press -> timed pulse -> timed lockout -> wait for release
   always_comb begin
      ch_out_d = 3'b000;
      for (int i = 0; i < 3; i++) begin
         ch_state_d[i] = ch_state_q[i];
         ch_cnt_d[i]   = ch_cnt_q[i];
         case (ch_state_q[i])
            ST_IDLE: begin
               if (ch_in[i]) begin
                  ch_state_d[i] = ST_PULSE;
                  ch_cnt_d[i]   = PULSE_LOAD;
                  ch_out_d[i]   = 1'b1;
               end
            end
            ST_PULSE: begin
               ch_out_d[i] = 1'b1;
               if (tick) begin
                  if (ch_cnt_q[i] <= 8'd1) begin
                     ch_out_d[i] = 1'b0;
                     if (GAP_FRAMES == 0) begin
                        ch_state_d[i] = ST_RELEASE;
                        ch_cnt_d[i]   = 8'd0;
                     end else begin
                        ch_state_d[i] = ST_GAP;
                        ch_cnt_d[i]   = GAP_LOAD;
                     end
                  end else begin
                     ch_cnt_d[i] = ch_cnt_q[i] - 8'd1;
                  end
               end
            end
            ST_GAP: begin
               if (tick) begin
                  if (ch_cnt_q[i] <= 8'd1) begin
                     ch_state_d[i] = ST_RELEASE;
                     ch_cnt_d[i]   = 8'd0;
                  end else begin
                     ch_cnt_d[i] = ch_cnt_q[i] - 8'd1;
                  end
               end
            end
            ST_RELEASE: begin
               if (!ch_in[i]) begin
                  ch_state_d[i] = ST_IDLE;
               end
            end
            default: begin
               ch_state_d[i] = ST_RELEASE;
               ch_cnt_d[i]   = 8'd0;
            end
         endcase
      end
   end

   // Pulse shaping state registers; reset parks every channel awaiting release
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            ch_state_q[i] <= ST_RELEASE;
            ch_cnt_q[i]   <= 8'd0;
         end
         ch_out_q <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            ch_state_q[i] <= ch_state_d[i];
            ch_cnt_q[i]   <= ch_cnt_d[i];
         end
         ch_out_q <= ch_out_d;
      end
   end

   assign start1 = ch_out_q[0];
   assign start2 = ch_out_q[1];
   assign coin   = ch_out_q[2];

`ifdef XEVIOUS_INPUT_AUTOFIRE_EN
   localparam logic [7:0] AF_LAST = 8'(AUTOFIRE_FRAMES - 1);

   logic [7:0] af_cnt_q, af_cnt_d;
   logic       af_lvl_q, af_lvl_d;

   // Autofire phase: level flips every AUTOFIRE_FRAMES ticks, restarting high on a new press
   always_comb begin
      af_cnt_d = 8'd0;
      af_lvl_d = 1'b1;
      fire_d   = in_r[4];
      if (autofire && in_r[4]) begin
         af_cnt_d = af_cnt_q;
         af_lvl_d = af_lvl_q;
         if (tick) begin
            if (af_cnt_q >= AF_LAST) begin
               af_cnt_d = 8'd0;
               af_lvl_d = ~af_lvl_q;
            end else begin
               af_cnt_d = af_cnt_q + 8'd1;
            end
         end
         fire_d = af_lvl_d;
      end
   end

   // Autofire phase registers
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         af_cnt_q <= 8'd0;
         af_lvl_q <= 1'b1;
      end else begin
         af_cnt_q <= af_cnt_d;
         af_lvl_q <= af_lvl_d;
      end
   end

   logic unused_bits;
   assign unused_bits = &{1'b0, joy_in[15:9]};
`else
   assign fire_d = in_r[4];

   logic unused_bits;
   assign unused_bits = &{1'b0, joy_in[15:9], autofire};
`endif

   // Registered directions, buttons and debug tick
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         up         <= 1'b0;
         down       <= 1'b0;
         left       <= 1'b0;
         right      <= 1'b0;
         fire       <= 1'b0;
         bomb       <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         up         <= ud_res[1];
         down       <= ud_res[0];
         left       <= lr_res[1];
         right      <= lr_res[0];
         fire       <= fire_d;
         bomb       <= in_r[5];
         frame_tick <= tick;
      end
   end

endmodule

// File: tb/tb_xevious_input_cond.sv
// tb_xevious_input_cond: scoreboard bench for xevious_input_cond (default build).
// A reference model built from timestamps and tick budgets predicts the outputs
// after every clock edge; a monitor process compares them on the falling edge.
module tb_xevious_input_cond;

   localparam int PULSE = 3;
   localparam int GAP   = 4;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        vblank;
   logic        pause;
   logic [15:0] joy_in;
   logic        socd_mode;
   logic        autofire;
   logic        up, down, left, right, fire, bomb, start1, start2, coin, frame_tick;

   always #5 clk_sys = ~clk_sys;

   xevious_input_cond #(
      .PULSE_FRAMES(PULSE),
      .GAP_FRAMES(GAP),
      .AUTOFIRE_FRAMES(2)
   ) dut (
      .clk_sys(clk_sys),
      .reset(reset),
      .vblank(vblank),
      .pause(pause),
      .joy_in(joy_in),
      .socd_mode(socd_mode),
      .autofire(autofire),
      .up(up),
      .down(down),
      .left(left),
      .right(right),
      .fire(fire),
      .bomb(bomb),
      .start1(start1),
      .start2(start2),
      .coin(coin),
      .frame_tick(frame_tick)
   );

   // Expected outputs after one clock edge: dir={up,down,left,right}, pls={coin,start1,start2}
   typedef struct packed {
      int         cyc;
      logic [3:0] dir;
      logic [1:0] btn;
      logic [2:0] pls;
      logic       tck;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   int          m_cyc = 10;
   logic [15:0] m_in = '0;
   logic [15:0] m_prev = '0;
   logic        m_vbd = 1'b1;
   int          hi_left  [3] = '{0, 0, 0};
   int          gap_left [3] = '{0, 0, 0};
   bit          locked   [3] = '{1, 1, 1};
   int          press_ts [4] = '{0, 1, 0, 1};
   int          ch_bit   [3] = '{8, 6, 7};

   // Stimulus globals
   logic [15:0] g_joy  = '0;
   logic        g_rst  = 1'b0;
   logic        g_pa   = 1'b0;
   logic        g_mode = 1'b0;
   logic        g_af   = 1'b0;
   int          vb_phase = 0;

   function automatic logic resolveSide(input logic a, input logic b, input int ta, input int tb,
                                        input logic mode);
      return a && (!b || (mode && (ta > tb)));
   endfunction

   task automatic modelStep(input logic [15:0] joy, input logic vb, input logic pa,
                            input logic rst, input logic mode, output exp_t e);
      logic t;
      m_cyc++;
      e     = '0;
      e.cyc = m_cyc;
      t     = vb && !m_vbd && !pa;
      if (rst) begin
         for (int c = 0; c < 3; c++) begin
            hi_left[c]  = 0;
            gap_left[c] = 0;
            locked[c]   = 1'b1;
         end
         press_ts[0] = 0;
         press_ts[1] = 1;
         press_ts[2] = 0;
         press_ts[3] = 1;
         m_vbd = 1'b1;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (m_in[b] && !m_prev[b]) press_ts[b] = m_cyc;
         end
         e.dir[3] = resolveSide(m_in[3], m_in[2], press_ts[3], press_ts[2], mode);
         e.dir[2] = resolveSide(m_in[2], m_in[3], press_ts[2], press_ts[3], mode);
         e.dir[1] = resolveSide(m_in[1], m_in[0], press_ts[1], press_ts[0], mode);
         e.dir[0] = resolveSide(m_in[0], m_in[1], press_ts[0], press_ts[1], mode);
         e.btn = {m_in[4], m_in[5]};
         for (int c = 0; c < 3; c++) begin
            logic o;
            o = 1'b0;
            if (hi_left[c] > 0) begin
               if (t) begin
                  hi_left[c]--;
                  if (hi_left[c] == 0) begin
                     gap_left[c] = GAP;
                     locked[c]   = 1'b1;
                  end
               end
               o = (hi_left[c] > 0);
            end else if (gap_left[c] > 0) begin
               if (t) gap_left[c]--;
            end else if (locked[c]) begin
               if (!m_in[ch_bit[c]]) locked[c] = 1'b0;
            end else if (m_in[ch_bit[c]]) begin
               hi_left[c] = PULSE;
               o = 1'b1;
            end
            e.pls[2-c] = o;
         end
         e.tck = t;
         m_vbd = vb;
      end
      m_prev = m_in;
      m_in   = joy;
   endtask

   // Drive one cycle of inputs, predict the post-edge outputs, and advance past the edge
   task automatic applyStimulus(input logic [15:0] joy, input logic vb, input logic pa,
                                input logic rst, input logic mode, input logic af);
      exp_t e;
      joy_in    = joy;
      vblank    = vb;
      pause     = pa;
      reset     = rst;
      socd_mode = mode;
      autofire  = af;
      modelStep(joy, vb, pa, rst, mode, e);
      exp_q.push_back(e);
      @(posedge clk_sys);
      #1;
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(g_joy, (vb_phase % 8) < 2, g_pa, g_rst, g_mode, g_af);
         vb_phase++;
      end
   endtask

   task automatic checkOutput(input string name, input int cyc, input logic [3:0] act,
                              input logic [3:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, req);
      end
   endtask

   // Monitor: every falling edge, compare DUT outputs with the oldest prediction
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_sys);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("dir", e.cyc, {up, down, left, right}, e.dir);
            checkOutput("btn", e.cyc, {2'b00, fire, bomb}, {2'b00, e.btn});
            checkOutput("pulse", e.cyc, {1'b0, coin, start1, start2}, {1'b0, e.pls});
            checkOutput("tick", e.cyc, {3'b000, frame_tick}, {3'b000, e.tck});
         end
      end
   end

   initial begin
      $display("[TB] start");
      // Coin held across reset release: must need a release before it pulses
      g_joy = 16'h0100;
      g_rst = 1'b1;
      runCycles(4);
      g_rst = 1'b0;
      runCycles(30);
      g_joy = 16'h0000;
      runCycles(5);
      g_joy = 16'h0100;
      runCycles(8 * 22);
      // Pulse then release during the gap and re-press at once
      g_joy = 16'h0000;
      runCycles(3);
      g_joy = 16'h0100;
      runCycles(34);
      g_joy = 16'h0000;
      runCycles(1);
      g_joy = 16'h0100;
      runCycles(60);
      g_joy = 16'h0000;
      runCycles(4);
      g_joy = 16'h0100;
      runCycles(30);
      // Pause during an active coin pulse
      g_joy = 16'h0000;
      runCycles(60);
      g_joy = 16'h0100;
      runCycles(10);
      g_pa = 1'b1;
      runCycles(80);
      g_pa = 1'b0;
      runCycles(60);
      g_joy = 16'h0000;
      runCycles(8);
      // SOCD neutral and last-pressed-wins on both axes
      g_mode = 1'b0;
      g_joy = 16'h000C; runCycles(5);
      g_joy = 16'h0003; runCycles(5);
      g_mode = 1'b1;
      g_joy = 16'h0000; runCycles(3);
      g_joy = 16'h0008; runCycles(3);
      g_joy = 16'h000C; runCycles(3);
      g_joy = 16'h0008; runCycles(3);
      g_joy = 16'h0000; runCycles(3);
      g_joy = 16'h000C; runCycles(4);
      g_joy = 16'h0004; runCycles(3);
      g_joy = 16'h000C; runCycles(3);
      g_joy = 16'h0001; runCycles(3);
      g_joy = 16'h0003; runCycles(3);
      g_joy = 16'h0002; runCycles(3);
      g_joy = 16'h0000; runCycles(3);
      g_joy = 16'h0003; runCycles(3);
      g_joy = 16'h0030; runCycles(4);
      // vblank rising exactly on the edge start1 enters its pulse
      g_joy = 16'h0000;
      for (int k = 0; k < 6; k++) applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, g_mode, 1'b0);
      applyStimulus(16'h0040, 1'b0, 1'b0, 1'b0, g_mode, 1'b0);
      applyStimulus(16'h0040, 1'b1, 1'b0, 1'b0, g_mode, 1'b0);
      vb_phase = 1;
      g_joy = 16'h0040;
      runCycles(50);
      g_joy = 16'h0000;
      runCycles(10);
      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 11) == 0) begin
            int b;
            b = $urandom_range(0, 8);
            g_joy[b] = ~g_joy[b];
         end
         if ($urandom_range(0, 3) == 0) g_joy[15:9] = 7'($urandom);
         if ($urandom_range(0, 63) == 0) g_mode = ~g_mode;
         if ($urandom_range(0, 149) == 0) g_pa = ~g_pa;
         g_af  = 1'($urandom_range(0, 1));
         g_rst = ($urandom_range(0, 599) == 0);
         runCycles(1);
      end
      g_rst = 1'b0;
      for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
         @(negedge clk_sys);
         #1;
      end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain got=%0d pending want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
